logic_gates_checker: RTL and testbench

Self-test sequencer and response checker for the two-input gate bank (and, nand, or, nor, xor, xnor, and not-of-a).
- Drives the bank's a/b inputs through all four input combinations.
- Waits a programmable settle time, samples the seven gate outputs and compares them against an internal golden truth table.
- Reports pass/fail, a saturating error count and the first failing vector.
- Sits beside the gate bank in the test harness or BIST wrapper.

---
 rtl/logic_gates_checker.sv | 169 ++++++++++++++++
 tb/tb_logic_gates_checker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gates_checker.sv
`default_nettype none
// ============================================================================
// Module   : logic_gates_checker
// Purpose  : Self-test sequencer and response checker for a two-input gate
//            bank; sweeps {a,b} through all four vectors and compares results.
// Revision : 1.0  initial release
// ============================================================================
module logic_gates_checker #(
    parameter int SETTLE = 2,
    parameter int PASSES = 1,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             p,
    input  logic             q,
    input  logic             r,
    input  logic             s,
    input  logic             t,
    input  logic             c,
    input  logic             d,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass_ok,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [1:0]       fail_vec,
    output logic [6:0]       fail_obs
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] c_SETTLE_LD = 8'(SETTLE - 1);
    localparam logic [3:0] c_PASS_LAST = 4'(PASSES - 1);

    // Golden {and,nand,or,nor,xor,xnor,not-a} indexed by {a,b}
    function automatic logic [6:0] golden(input logic [1:0] v);
        logic [6:0] g;
        case (v)
            2'b00:   g = 7'h2B;
            2'b01:   g = 7'h35;
            2'b10:   g = 7'h34;
            default: g = 7'h52;
        endcase
        return g;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [3:0]       pass_q, pass_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fv_q, fv_d;
    logic [1:0]       fvec_q, fvec_d;
    logic [6:0]       fobs_q, fobs_d;
    logic             pass_ok_q, pass_ok_d;

    logic [6:0]       w_obs;
    logic             w_mismatch;

    assign w_obs      = {p, q, r, s, t, c, d};
    assign w_mismatch = (w_obs != golden(vec_q));

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        pass_d    = pass_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        fv_d      = fv_q;
        fvec_d    = fvec_q;
        fobs_d    = fobs_q;
        pass_ok_d = pass_ok_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SETTLE;
                    vec_d     = 2'd0;
                    pass_d    = 4'd0;
                    cnt_d     = c_SETTLE_LD;
                    err_d     = '0;
                    fv_d      = 1'b0;
                    fvec_d    = 2'd0;
                    fobs_d    = 7'd0;
                    pass_ok_d = 1'b0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_CHECK: begin
                if (w_mismatch) begin
                    if (err_q != {ERR_W{1'b1}}) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!fv_q) begin
                        fv_d   = 1'b1;
                        fvec_d = vec_q;
                        fobs_d = w_obs;
                    end
                end
                cnt_d = c_SETTLE_LD;
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    state_d = S_SETTLE;
                end else if (pass_q != c_PASS_LAST) begin
                    vec_d   = 2'd0;
                    pass_d  = pass_q + 4'd1;
                    state_d = S_SETTLE;
                end else begin
                    // Uses err_d so a final-vector mismatch is reflected
                    pass_ok_d = (err_d == '0);
                    state_d   = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            vec_q     <= 2'd0;
            pass_q    <= 4'd0;
            cnt_q     <= 8'd0;
            err_q     <= '0;
            fv_q      <= 1'b0;
            fvec_q    <= 2'd0;
            fobs_q    <= 7'd0;
            pass_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            pass_q    <= pass_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            fv_q      <= fv_d;
            fvec_q    <= fvec_d;
            fobs_q    <= fobs_d;
            pass_ok_q <= pass_ok_d;
        end
    end

    assign a          = vec_q[1];
    assign b          = vec_q[0];
    assign busy       = (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done       = (state_q == S_DONE);
    assign pass_ok    = pass_ok_q;
    assign err_cnt    = err_q;
    assign fail_valid = fv_q;
    assign fail_vec   = fvec_q;
    assign fail_obs   = fobs_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_gates_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_gates_checker
// Purpose  : Scoreboard bench for logic_gates_checker across three configs.
// Revision : 1.0  initial release
// ============================================================================
module tb_logic_gates_checker;

    typedef struct packed {
        logic [1:0] inst;
        logic       pass_ok;
        logic [7:0] err;
        logic       fv;
        logic [1:0] fvec;
        logic [6:0] fobs;
        logic [7:0] lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    int   mode0 = 0, mode1 = 0, mode2 = 0;
    int   cyc = 0;
    int   s_cyc [3];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt0 = 0;
    exp_t exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate bank model with optional fault injection: 1=p stuck 1, 2=d stuck 0, 3=invert all
    function automatic logic [6:0] bank(input logic a, input logic b, input int mode);
        logic [6:0] g;
        g = {a & b, ~(a & b), a | b, ~(a | b), a ^ b, ~(a ^ b), ~a};
        case (mode)
            1: g[6] = 1'b1;
            2: g[0] = 1'b0;
            3: g = ~g;
            default: ;
        endcase
        return g;
    endfunction

    logic a0, b0, busy0, done0, pok0, fv0;
    logic a1, b1, busy1, done1, pok1, fv1;
    logic a2, b2, busy2, done2, pok2, fv2;
    logic [7:0] err0, err1;
    logic [1:0] err2;
    logic [1:0] fvec0, fvec1, fvec2;
    logic [6:0] fobs0, fobs1, fobs2;
    logic [6:0] obs0, obs1, obs2;

    assign obs0 = bank(a0, b0, mode0);
    assign obs1 = bank(a1, b1, mode1);
    assign obs2 = bank(a2, b2, mode2);

    logic_gates_checker u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .p(obs0[6]), .q(obs0[5]), .r(obs0[4]), .s(obs0[3]), .t(obs0[2]), .c(obs0[1]), .d(obs0[0]),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass_ok(pok0), .err_cnt(err0),
        .fail_valid(fv0), .fail_vec(fvec0), .fail_obs(fobs0)
    );

    logic_gates_checker #(.SETTLE(1), .PASSES(3), .ERR_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .p(obs1[6]), .q(obs1[5]), .r(obs1[4]), .s(obs1[3]), .t(obs1[2]), .c(obs1[1]), .d(obs1[0]),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass_ok(pok1), .err_cnt(err1),
        .fail_valid(fv1), .fail_vec(fvec1), .fail_obs(fobs1)
    );

    logic_gates_checker #(.SETTLE(2), .PASSES(2), .ERR_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .p(obs2[6]), .q(obs2[5]), .r(obs2[4]), .s(obs2[3]), .t(obs2[2]), .c(obs2[1]), .d(obs2[0]),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .pass_ok(pok2), .err_cnt(err2),
        .fail_valid(fv2), .fail_vec(fvec2), .fail_obs(fobs2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input int k, input logic pok, input logic [7:0] err,
                            input logic fv, input logic [1:0] fvec, input logic [6:0] fobs);
        exp_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_done: inst %0d got done with no run expected", k);
        end else begin
            e = exp_q.pop_front();
            chk("sb_inst",     32'(k),             32'(e.inst));
            chk("sb_pass_ok",  32'(pok),           32'(e.pass_ok));
            chk("sb_err_cnt",  32'(err),           32'(e.err));
            chk("sb_fail_val", 32'(fv),            32'(e.fv));
            chk("sb_fail_vec", 32'(fvec),          32'(e.fvec));
            chk("sb_fail_obs", 32'(fobs),          32'(e.fobs));
            chk("sb_latency",  32'(cyc - s_cyc[k]), 32'(e.lat));
        end
    endtask

    always @(negedge clk) begin
        if (done0) begin
            done_cnt0++;
            sb_check(0, pok0, err0, fv0, fvec0, fobs0);
        end
        if (done1) sb_check(1, pok1, err1, fv1, fvec1, fobs1);
        if (done2) sb_check(2, pok2, {6'd0, err2}, fv2, fvec2, fobs2);
    end

    task automatic pulse_start(input int k);
        @(negedge clk);
        case (k)
            0: start0 = 1'b1;
            1: start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        @(posedge clk);
        #1;
        s_cyc[k] = cyc;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d done pulses never arrived", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ab",    32'({a0, b0}), 32'd0);
        chk("rst_busy",  32'(busy0),    32'd0);
        chk("rst_done",  32'(done0),    32'd0);
        chk("rst_pok",   32'(pok0),     32'd0);
        chk("rst_err",   32'(err0),     32'd0);
        chk("rst_fv",    32'(fv0),      32'd0);
        chk("rst_fobs",  32'(fobs0),    32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Clean sweep, defaults: each vector held 3 cycles
        exp_q.push_back('{inst: 2'd0, pass_ok: 1'b1, err: 8'd0, fv: 1'b0, fvec: 2'd0, fobs: 7'h00, lat: 8'd12});
        pulse_start(0);
        for (int k = 0; k < 12; k++) begin
            chk("seq_ab",   32'({a0, b0}), 32'(k / 3));
            chk("seq_busy", 32'(busy0),    32'd1);
            @(posedge clk);
            #1;
        end
        wait_drain();
        chk("idle_ab_hold", 32'({a0, b0}), 32'd3);
        chk("idle_busy",    32'(busy0),    32'd0);

        // p stuck high
        mode0 = 1;
        exp_q.push_back('{inst: 2'd0, pass_ok: 1'b0, err: 8'd3, fv: 1'b1, fvec: 2'd0, fobs: 7'h6B, lat: 8'd12});
        pulse_start(0);
        wait_drain();
        chk("hold_pok", 32'(pok0), 32'd0);
        chk("hold_err", 32'(err0), 32'd3);

        // Three passes, single-cycle settle, d stuck low
        mode1 = 2;
        exp_q.push_back('{inst: 2'd1, pass_ok: 1'b0, err: 8'd6, fv: 1'b1, fvec: 2'd0, fobs: 7'h2A, lat: 8'd24});
        pulse_start(1);
        wait_drain();

        // Narrow counter saturates with everything inverted
        mode2 = 3;
        exp_q.push_back('{inst: 2'd2, pass_ok: 1'b0, err: 8'd3, fv: 1'b1, fvec: 2'd0, fobs: 7'h54, lat: 8'd24});
        pulse_start(2);
        wait_drain();

        // Asynchronous reset during settle of vector 2
        mode0 = 1;
        pulse_start(0);
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_ab",  32'({a0, b0}), 32'd2);
        chk("pre_rst_err", 32'(err0),     32'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy0),    32'd0);
        chk("mid_rst_ab",   32'({a0, b0}), 32'd0);
        chk("mid_rst_err",  32'(err0),     32'd0);
        chk("mid_rst_fv",   32'(fv0),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        mode0 = 0;
        exp_q.push_back('{inst: 2'd0, pass_ok: 1'b1, err: 8'd0, fv: 1'b0, fvec: 2'd0, fobs: 7'h00, lat: 8'd12});
        pulse_start(0);
        wait_drain();

        // start held through the whole run: exactly one done
        done_cnt0 = 0;
        exp_q.push_back('{inst: 2'd0, pass_ok: 1'b1, err: 8'd0, fv: 1'b0, fvec: 2'd0, fobs: 7'h00, lat: 8'd12});
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        s_cyc[0] = cyc;
        repeat (12) @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("restart_done_cnt", 32'(done_cnt0), 32'd1);
        chk("restart_busy",     32'(busy0),     32'd0);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
